rrf_tag_alloc: RTL and testbench
================================

Name: rrf_tag_alloc

Overview:
- Allocator for the rename register file. Up to two RRF tags per cycle are issued at dispatch, in circular order. Up to two tags per cycle are returned at commit, also in order.
- Drives the RRF's dispatch-clear port (dpen1/dpen2, dpaddr1/dpaddr2) and commit-read port (com1tag/com2tag).
- Sits between the rename/dispatch stage and the RRF, and is fed by the ROB commit logic.

Parameters:
- RRF_NUM, 64, number of rename registers; must be a power of two, minimum 4.
- RRF_SEL, 6, tag width; equals log2(RRF_NUM).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req1  in  1  dispatch slot 1 needs a tag
- req2  in  1  dispatch slot 2 needs a tag
- stall_in  in  1  dispatch stalled downstream; no allocation this cycle
- dpen1  out  1  slot 1 tag allocated this cycle
- dpen2  out  1  slot 2 tag allocated this cycle
- dpaddr1  out  RRF_SEL  tag for slot 1
- dpaddr2  out  RRF_SEL  tag for slot 2
- alloc_stall  out  1  insufficient free tags for the current request
- com1en  in  1  commit frees the oldest tag
- com2en  in  1  commit frees the second-oldest tag
- com1tag  out  RRF_SEL  oldest in-flight tag (equals comptr)
- com2tag  out  RRF_SEL  comptr+1 mod RRF_NUM
- freenum  out  RRF_SEL+1  number of free tags
- rrfptr  out  RRF_SEL  next tag to allocate
- err  out  1  sticky: illegal commit was attempted

Behaviour:
- Reset: rrfptr=0, comptr=0, freenum=RRF_NUM, err=0.
  - All dp*/com* outputs follow combinationally from this reset state.
  - Asserting reset mid-operation discards all in-flight tags.
- reqnum = req1+req2 (0..2).
- alloc_stall = (reqnum > freenum). Combinational; uses the registered freenum only. Tags freed this cycle are not visible until the next cycle.
- go = ~alloc_stall & ~stall_in. Allocation is all-or-nothing: no partial grant.
- dpen1 = req1 & go; dpen2 = req2 & go.
- dpaddr1 = rrfptr.
- dpaddr2 = req1 ? rrfptr+1 : rrfptr, wrapping mod RRF_NUM. A lone req2 takes rrfptr.
- allocnum = dpen1+dpen2.
- Commit:
  - comnum = com1en + (com1en & com2en). com2en without com1en is ignored and sets err.
  - If comnum > (RRF_NUM - freenum), i.e. freeing more tags than are in flight: the commit is dropped entirely and err is set.
- Next state, all in the same edge:
  - rrfptr += allocnum (mod RRF_NUM)
  - comptr += comnum (mod RRF_NUM)
  - freenum = freenum - allocnum + comnum
- Invariant: (comptr + (RRF_NUM - freenum)) mod RRF_NUM == rrfptr.
- Full (freenum=0): any request stalls; rrfptr==comptr. Commit still proceeds.
- Empty (freenum=RRF_NUM): commit is illegal as defined above.
- Latency: grant is same-cycle combinational. Pointers and count update at the next clock edge.
- err clears only on reset.

Optional Feature:
- Macro RRF_ROLLBACK_EN.
- Defined: adds inputs rollback_en (1) and rollback_ptr (RRF_SEL), for branch-mispredict recovery.
  - When rollback_en=1: dpen1/dpen2 are forced to 0 and alloc_stall=1.
  - Same-cycle commits are honoured.
  - rrfptr <= rollback_ptr.
  - freenum <= RRF_NUM - ((rollback_ptr - comptr_next) mod RRF_NUM).
  - rollback_ptr == comptr_next means all tags are free.
- Undefined: these ports do not exist, and the pointers only advance.

Test Plan:
- Reset, then req1=req2=1 for 3 cycles -> dpaddr pairs (0,1), (2,3), (4,5); rrfptr=6; freenum=58.
- Allocate 64 tags with no commit, then req1=1 -> alloc_stall=1, dpen1=0, freenum=0. Next, com1en=com2en=1 -> com1tag=0, com2tag=1; freenum=2; request granted on the following cycle.
- freenum=1, req1=req2=1 with com1en=1 in the same cycle -> stall this cycle, freenum=2 next cycle, then both granted.
- rrfptr=63, req1=req2=1 -> dpaddr1=63, dpaddr2=0; rrfptr=1 (wrap).
- From reset state, com1en=1 -> no pointer change, err=1 and held until reset. Separately, com2en alone -> err=1.
- RRF_ROLLBACK_EN defined: comptr=4, rrfptr=20, rollback_en=1, rollback_ptr=10 -> no grant; next cycle rrfptr=10, freenum=58. With com1en=1 in the same cycle: comptr=5, freenum=59.

Source files
------------

// File: rtl/rrf_tag_alloc.sv
// rtl/rrf_tag_alloc.sv - circular RRF tag allocator: two-wide dispatch grant, two-wide in-order commit
// Optional macro RRF_ROLLBACK_EN adds rollback_en/rollback_ptr for branch-mispredict recovery.
module rrf_tag_alloc #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req1,
  input  logic               req2,
  input  logic               stall_in,
  input  logic               com1en,
  input  logic               com2en,
`ifdef RRF_ROLLBACK_EN
  input  logic               rollback_en,
  input  logic [RRF_SEL-1:0] rollback_ptr,
`endif
  output logic               dpen1,
  output logic               dpen2,
  output logic [RRF_SEL-1:0] dpaddr1,
  output logic [RRF_SEL-1:0] dpaddr2,
  output logic               alloc_stall,
  output logic [RRF_SEL-1:0] com1tag,
  output logic [RRF_SEL-1:0] com2tag,
  output logic [RRF_SEL:0]   freenum,
  output logic [RRF_SEL-1:0] rrfptr,
  output logic               err
);

  localparam logic [RRF_SEL:0] FREE_ALL = (RRF_SEL+1)'(RRF_NUM);

  logic [RRF_SEL-1:0] rrfptr_q, rrfptr_d;
  logic [RRF_SEL-1:0] comptr_q, comptr_d;
  logic [RRF_SEL:0]   freenum_q, freenum_d;
  logic               err_q, err_d;

  logic [RRF_SEL:0]   reqnum;
  logic [RRF_SEL:0]   allocnum;
  logic [RRF_SEL:0]   inflight;
  logic [RRF_SEL:0]   comnum_raw;
  logic [RRF_SEL:0]   comnum;
  logic               com_over;
  logic               com_bad;
  logic               go;

  // Grant is judged against the registered free count only; tags freed this
  // cycle become usable on the next one.
  assign reqnum = (RRF_SEL+1)'(req1) + (RRF_SEL+1)'(req2);
`ifdef RRF_ROLLBACK_EN
  assign alloc_stall = (reqnum > freenum_q) | rollback_en;
`else
  assign alloc_stall = (reqnum > freenum_q);
`endif
  assign go       = ~alloc_stall & ~stall_in;
  assign dpen1    = req1 & go;
  assign dpen2    = req2 & go;
  assign dpaddr1  = rrfptr_q;
  assign dpaddr2  = req1 ? rrfptr_q + 1'b1 : rrfptr_q;
  assign allocnum = (RRF_SEL+1)'(dpen1) + (RRF_SEL+1)'(dpen2);

  // A commit that would free more tags than are in flight is dropped whole;
  // com2en without com1en frees nothing. Both cases are flagged.
  assign inflight   = FREE_ALL - freenum_q;
  assign comnum_raw = (RRF_SEL+1)'(com1en) + (RRF_SEL+1)'(com1en & com2en);
  assign com_over   = comnum_raw > inflight;
  assign comnum     = com_over ? '0 : comnum_raw;
  assign com_bad    = (com2en & ~com1en) | com_over;

  assign com1tag = comptr_q;
  assign com2tag = comptr_q + 1'b1;
  assign freenum = freenum_q;
  assign rrfptr  = rrfptr_q;
  assign err     = err_q;

  // Next-state: both pointers and the free count move together on one edge.
  always_comb begin
    comptr_d  = comptr_q + comnum[RRF_SEL-1:0];
    rrfptr_d  = rrfptr_q + allocnum[RRF_SEL-1:0];
    freenum_d = freenum_q - allocnum + comnum;
    err_d     = err_q | com_bad;
`ifdef RRF_ROLLBACK_EN
    if (rollback_en) begin
      // Everything younger than rollback_ptr is squashed; the distance from
      // the post-commit oldest tag gives the surviving in-flight count.
      rrfptr_d  = rollback_ptr;
      freenum_d = FREE_ALL - {1'b0, rollback_ptr - comptr_d};
    end
`endif
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrfptr_q  <= '0;
      comptr_q  <= '0;
      freenum_q <= FREE_ALL;
      err_q     <= 1'b0;
    end else begin
      rrfptr_q  <= rrfptr_d;
      comptr_q  <= comptr_d;
      freenum_q <= freenum_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_rrf_tag_alloc.sv
// tb/tb_rrf_tag_alloc.sv - self-checking bench for rrf_tag_alloc against a tag-queue model
module tb_rrf_tag_alloc;

  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, req1, req2, stall_in, com1en, com2en;
  logic       rb_en;
  logic [5:0] rb_ptr;
  logic       dpen1, dpen2, alloc_stall, err;
  logic [5:0] dpaddr1, dpaddr2, com1tag, com2tag, rrfptr;
  logic [6:0] freenum;

  rrf_tag_alloc #(.RRF_NUM(64), .RRF_SEL(6)) dut (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2), .stall_in(stall_in),
    .com1en(com1en), .com2en(com2en),
`ifdef RRF_ROLLBACK_EN
    .rollback_en(rb_en), .rollback_ptr(rb_ptr),
`endif
    .dpen1(dpen1), .dpen2(dpen2), .dpaddr1(dpaddr1), .dpaddr2(dpaddr2),
    .alloc_stall(alloc_stall), .com1tag(com1tag), .com2tag(com2tag),
    .freenum(freenum), .rrfptr(rrfptr), .err(err)
  );

  // Model: the in-flight tags themselves, oldest first, plus the next tag.
  int q[$];
  int m_next;
  bit m_err;
  int n_checks = 0;
  int n_fail = 0;

  bit e_stall, e_dpen1, e_dpen2, e_grant;
  int e_a1, e_a2, e_c1, e_c2, e_free;

  task automatic apply(input bit r1, input bit r2, input bit st, input bit c1, input bit c2);
    int need;
    req1 = r1; req2 = r2; stall_in = st; com1en = c1; com2en = c2;
    need    = int'(r1) + int'(r2);
    e_free  = N - q.size();
    e_stall = (need > e_free) || rb_en;
    e_grant = !e_stall && !st;
    e_dpen1 = r1 && e_grant;
    e_dpen2 = r2 && e_grant;
    e_a1    = m_next;
    e_a2    = r1 ? (m_next + 1) % N : m_next;
    e_c1    = (m_next - q.size() + N) % N;
    e_c2    = (e_c1 + 1) % N;
    #1;
  endtask

  task automatic tick();
    int n, com, keep;
    @(posedge clk);
    if (reset) begin
      q.delete(); m_next = 0; m_err = 0;
    end else begin
      n = int'(com1en) + int'(com1en && com2en);
      if (com2en && !com1en) m_err = 1;
      if (n > q.size()) begin m_err = 1; n = 0; end
      repeat (n) void'(q.pop_front());
      if (rb_en) begin
        com  = (m_next - q.size() + N) % N;
        keep = (int'(rb_ptr) - com + N) % N;
        q.delete();
        for (int i = 0; i < keep; i++) q.push_back((com + i) % N);
        m_next = int'(rb_ptr);
      end else begin
        if (e_dpen1) begin q.push_back(m_next); m_next = (m_next + 1) % N; end
        if (e_dpen2) begin q.push_back(m_next); m_next = (m_next + 1) % N; end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    apply(0, 0, 0, 0, 0);
    n_checks++; if (freenum !== 7'd64) begin n_fail++; $display("FAIL reset_freenum got %0d want 64", freenum); end
    n_checks++; if (rrfptr !== 6'd0) begin n_fail++; $display("FAIL reset_rrfptr got %0d want 0", rrfptr); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err); end
    n_checks++; if (com1tag !== 6'd0 || com2tag !== 6'd1) begin n_fail++; $display("FAIL reset_comtag got %0d,%0d want 0,1", com1tag, com2tag); end
    n_checks++; if (alloc_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", alloc_stall); end
  endtask

  task automatic test_pairs();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 0, 0, 0);
      n_checks++;
      if (dpen1 !== 1'b1 || dpen2 !== 1'b1 || dpaddr1 !== 6'(2*i) || dpaddr2 !== 6'(2*i+1)) begin
        n_fail++; $display("FAIL pair%0d got en=%0b%0b addr=%0d,%0d want 11 %0d,%0d", i, dpen1, dpen2, dpaddr1, dpaddr2, 2*i, 2*i+1);
      end
      tick();
    end
    apply(0, 0, 0, 0, 0);
    n_checks++; if (rrfptr !== 6'd6 || freenum !== 7'd58) begin n_fail++; $display("FAIL pairs_end got rrfptr=%0d freenum=%0d want 6,58", rrfptr, freenum); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 32; i++) begin apply(1, 1, 0, 0, 0); tick(); end
    apply(1, 0, 0, 0, 0);
    n_checks++; if (alloc_stall !== 1'b1 || dpen1 !== 1'b0 || freenum !== 7'd0) begin n_fail++; $display("FAIL full_stall got stall=%0b dpen1=%0b free=%0d want 1,0,0", alloc_stall, dpen1, freenum); end
    n_checks++; if (rrfptr !== com1tag) begin n_fail++; $display("FAIL full_ptr_eq got rrfptr=%0d com1tag=%0d want equal", rrfptr, com1tag); end
    tick();
    apply(0, 0, 0, 1, 1);
    n_checks++; if (com1tag !== 6'd0 || com2tag !== 6'd1) begin n_fail++; $display("FAIL full_comtag got %0d,%0d want 0,1", com1tag, com2tag); end
    tick();
    apply(1, 0, 0, 0, 0);
    n_checks++; if (freenum !== 7'd2 || dpen1 !== 1'b1 || dpaddr1 !== 6'd0) begin n_fail++; $display("FAIL full_regrant got free=%0d dpen1=%0b addr=%0d want 2,1,0", freenum, dpen1, dpaddr1); end
    tick();
  endtask

  task automatic test_commit_overlap();
    do_reset();
    for (int i = 0; i < 31; i++) begin apply(1, 1, 0, 0, 0); tick(); end
    apply(1, 0, 0, 0, 0); tick();
    apply(1, 1, 0, 1, 0);
    n_checks++; if (freenum !== 7'd1 || alloc_stall !== 1'b1 || dpen1 !== 1'b0 || dpen2 !== 1'b0) begin n_fail++; $display("FAIL overlap_stall got free=%0d stall=%0b en=%0b%0b want 1,1,00", freenum, alloc_stall, dpen1, dpen2); end
    tick();
    apply(1, 1, 0, 0, 0);
    n_checks++; if (freenum !== 7'd2 || dpen1 !== 1'b1 || dpen2 !== 1'b1) begin n_fail++; $display("FAIL overlap_grant got free=%0d en=%0b%0b want 2,11", freenum, dpen1, dpen2); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    apply(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 62; i++) begin apply(1, 0, 0, 1, 0); tick(); end
    apply(0, 1, 0, 0, 0);
    n_checks++; if (dpaddr2 !== 6'd63 || rrfptr !== 6'd63) begin n_fail++; $display("FAIL lone_req2 got addr2=%0d rrfptr=%0d want 63,63", dpaddr2, rrfptr); end
    apply(1, 1, 1, 0, 0);
    n_checks++; if (dpen1 !== 1'b0 || dpen2 !== 1'b0 || alloc_stall !== 1'b0) begin n_fail++; $display("FAIL stall_in got en=%0b%0b stall=%0b want 00,0", dpen1, dpen2, alloc_stall); end
    tick();
    apply(1, 1, 0, 0, 0);
    n_checks++; if (dpaddr1 !== 6'd63 || dpaddr2 !== 6'd0 || dpen2 !== 1'b1) begin n_fail++; $display("FAIL wrap_addr got %0d,%0d en2=%0b want 63,0,1", dpaddr1, dpaddr2, dpen2); end
    tick();
    apply(0, 0, 0, 0, 0);
    n_checks++; if (rrfptr !== 6'd1) begin n_fail++; $display("FAIL wrap_rrfptr got %0d want 1", rrfptr); end
  endtask

  task automatic test_err();
    do_reset();
    apply(0, 0, 0, 1, 0);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_early got %0b want 0", err); end
    tick();
    apply(0, 0, 0, 0, 0);
    n_checks++; if (err !== 1'b1 || rrfptr !== 6'd0 || com1tag !== 6'd0 || freenum !== 7'd64) begin n_fail++; $display("FAIL err_empty got err=%0b rrfptr=%0d com1=%0d free=%0d want 1,0,0,64", err, rrfptr, com1tag, freenum); end
    repeat (3) tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b want 1", err); end
    do_reset();
    apply(1, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 1); tick();
    apply(0, 0, 0, 0, 0);
    n_checks++; if (err !== 1'b1 || freenum !== 7'd63) begin n_fail++; $display("FAIL err_com2only got err=%0b free=%0d want 1,63", err, freenum); end
  endtask

`ifdef RRF_ROLLBACK_EN
  task automatic test_rollback();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i < 10; i++) begin apply(1, 1, 0, 0, 0); tick(); end
      for (int i = 0; i < 2; i++) begin apply(0, 0, 0, 1, 1); tick(); end
      rb_en = 1'b1; rb_ptr = 6'd10;
      apply(1, 1, 0, k == 1, 0);
      n_checks++; if (dpen1 !== 1'b0 || dpen2 !== 1'b0 || alloc_stall !== 1'b1) begin n_fail++; $display("FAIL rb_nogrant%0d got en=%0b%0b stall=%0b want 00,1", k, dpen1, dpen2, alloc_stall); end
      tick();
      rb_en = 1'b0;
      apply(0, 0, 0, 0, 0);
      n_checks++; if (rrfptr !== 6'd10 || freenum !== 7'(58 + k) || com1tag !== 6'(4 + k)) begin n_fail++; $display("FAIL rb_state%0d got rrfptr=%0d free=%0d com=%0d want 10,%0d,%0d", k, rrfptr, freenum, com1tag, 58 + k, 4 + k); end
    end
  endtask
`endif

  task automatic test_random();
    bit r1, r2, st, c1, c2;
    int bias;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bias = (i / 300) % 3;
      r1 = $urandom_range(0, 3) != 0;
      r2 = $urandom_range(0, 1) != 0;
      st = $urandom_range(0, 9) == 0;
      c1 = $urandom_range(0, 3) < bias + 1;
      c2 = $urandom_range(0, 1) != 0;
      reset = $urandom_range(0, 499) == 0;
      apply(r1, r2, st, c1, c2);
      n_checks++;
      if (dpen1 !== e_dpen1 || dpen2 !== e_dpen2 || alloc_stall !== e_stall) begin
        n_fail++; $display("FAIL rnd_grant cyc%0d got en=%0b%0b stall=%0b want %0b%0b,%0b", i, dpen1, dpen2, alloc_stall, e_dpen1, e_dpen2, e_stall);
      end
      n_checks++;
      if (int'(dpaddr1) != e_a1 || int'(dpaddr2) != e_a2 || int'(rrfptr) != m_next) begin
        n_fail++; $display("FAIL rnd_addr cyc%0d got %0d,%0d ptr=%0d want %0d,%0d ptr=%0d", i, dpaddr1, dpaddr2, rrfptr, e_a1, e_a2, m_next);
      end
      n_checks++;
      if (int'(com1tag) != e_c1 || int'(com2tag) != e_c2 || int'(freenum) != e_free || err !== m_err) begin
        n_fail++; $display("FAIL rnd_state cyc%0d got com=%0d,%0d free=%0d err=%0b want %0d,%0d,%0d,%0b", i, com1tag, com2tag, freenum, err, e_c1, e_c2, e_free, m_err);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req1 = 0; req2 = 0; stall_in = 0; com1en = 0; com2en = 0;
    rb_en = 1'b0; rb_ptr = 6'd0;
    m_next = 0; m_err = 0;
    @(posedge clk); #1;
    test_reset();
    test_pairs();
    test_full();
    test_commit_overlap();
    test_wrap();
    test_err();
`ifdef RRF_ROLLBACK_EN
    test_rollback();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
